// File: rtl/user_wb_router_pkg.sv
// Shared types and decode constants for the Wishbone router slice.
package user_wb_router_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned IDX_W  = 2;
  localparam int unsigned TMO_W  = 9;
  localparam int unsigned CNT_W  = 8;

  localparam logic [7:0]  DEC_BASE = 8'h30;
  localparam logic [20:0] DEC_DBG  = 21'h1FFFFF;
  localparam logic [7:0]  DEC_GPIO = 8'h01;
  localparam logic [31:0] ERR_DATA = 32'hDEADBEEF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef logic [IDX_W-1:0] idx_t;

  // Request captured in IDLE and replayed to the selected slave
  typedef struct packed {
    logic              we;
    logic [3:0]        sel;
    logic [DATA_W-1:0] adr;
    logic [DATA_W-1:0] dat;
    idx_t              idx;
  } req_t;

endpackage

// File: rtl/user_wb_router_if.sv
// Upstream Wishbone slave port plus the shared downstream slave bus.
interface user_wb_router_if
  import user_wb_router_pkg::*;
#(
  parameter int unsigned NSLV = 3
) ();

  logic                   wbs_cyc_i;
  logic                   wbs_stb_i;
  logic                   wbs_we_i;
  logic [3:0]             wbs_sel_i;
  logic [DATA_W-1:0]      wbs_adr_i;
  logic [DATA_W-1:0]      wbs_dat_i;
  logic                   wbs_ack_o;
  logic [DATA_W-1:0]      wbs_dat_o;

  logic [NSLV-1:0]        s_cyc_o;
  logic                   s_stb_o;
  logic                   s_we_o;
  logic [3:0]             s_sel_o;
  logic [DATA_W-1:0]      s_adr_o;
  logic [DATA_W-1:0]      s_dat_o;
  logic [NSLV-1:0]        s_ack_i;
  logic [NSLV*DATA_W-1:0] s_dat_i;

  // Router side
  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o,
    output s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o,
    input  s_ack_i, s_dat_i
  );

  // Environment side: upstream master and downstream slaves
  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o,
    input  s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o,
    output s_ack_i, s_dat_i
  );

endinterface

// File: rtl/user_wb_addr_decode.sv
// Combinational address decode: slave index and decode-error flag.
module user_wb_addr_decode
  import user_wb_router_pkg::*;
(
  input  logic [31:3] adr,
  output idx_t        idx,
  output logic        decerr
);

  always_comb begin
    idx    = IDX_W'(0);
    decerr = 1'b0;
    if (adr[31:24] != DEC_BASE) begin
      decerr = 1'b1;
    end else if (adr[23:3] == DEC_DBG) begin
      idx = IDX_W'(2);
    end else if (adr[23:16] == DEC_GPIO) begin
      idx = IDX_W'(1);
    end
  end

endmodule

// File: rtl/user_wb_router.sv
// Single-outstanding Wishbone router: decode, forward to one slave, respond,
// with timeout, decode-error response and a sticky error interrupt/counter.
module user_wb_router
  import user_wb_router_pkg::*;
#(
  parameter int unsigned NSLV    = 3,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_n,
  user_wb_router_if.slave  bus,
  output logic             err_irq_o,
  input  logic             irq_clr_i,
  output logic [CNT_W-1:0] err_cnt_o
);

  state_e            state_q, state_d;
  req_t              req_q, req_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [NSLV-1:0]   cyc_q, cyc_d;
  logic              stb_q, stb_d;
  logic              ack_q, ack_d;
  logic [DATA_W-1:0] rdat_q, rdat_d;
  logic              irq_q, irq_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  idx_t              dec_idx;
  logic              dec_err;
  logic              sel_ack;
  logic [DATA_W-1:0] sel_dat;
  logic              err_evt;

  user_wb_addr_decode u_decode (
    .adr    (bus.wbs_adr_i[31:3]),
    .idx    (dec_idx),
    .decerr (dec_err)
  );

  // Ack and read data from the latched slave only
  always_comb begin
    sel_ack = 1'b0;
    sel_dat = '0;
    for (int unsigned k = 0; k < NSLV; k++) begin
      if (req_q.idx == IDX_W'(k)) begin
        sel_ack = bus.s_ack_i[k];
        sel_dat = bus.s_dat_i[k*DATA_W +: DATA_W];
      end
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    tmo_d   = tmo_q;
    cyc_d   = cyc_q;
    stb_d   = stb_q;
    ack_d   = 1'b0;
    rdat_d  = rdat_q;
    irq_d   = irq_q & ~irq_clr_i;
    cnt_d   = cnt_q;
    err_evt = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.wbs_cyc_i && bus.wbs_stb_i) begin
          req_d = '{we:  bus.wbs_we_i,  sel: bus.wbs_sel_i,
                    adr: bus.wbs_adr_i, dat: bus.wbs_dat_i, idx: dec_idx};
          tmo_d = '0;
          if (dec_err) begin
            state_d = ST_RESP;
            ack_d   = 1'b1;
            rdat_d  = ERR_DATA;
            err_evt = 1'b1;
          end else begin
            state_d = ST_BUSY;
            stb_d   = 1'b1;
            for (int unsigned k = 0; k < NSLV; k++) begin
              cyc_d[k] = (dec_idx == IDX_W'(k));
            end
          end
        end
      end
      ST_BUSY: begin
        // Abort beats ack and timeout: the master has walked away
        if (!bus.wbs_cyc_i) begin
          state_d = ST_IDLE;
          cyc_d   = '0;
          stb_d   = 1'b0;
        end else if (sel_ack) begin
          state_d = ST_RESP;
          ack_d   = 1'b1;
          rdat_d  = sel_dat;
          cyc_d   = '0;
          stb_d   = 1'b0;
        end else if (tmo_q + TMO_W'(1) == TMO_W'(TIMEOUT)) begin
          state_d = ST_RESP;
          ack_d   = 1'b1;
          rdat_d  = ERR_DATA;
          err_evt = 1'b1;
          cyc_d   = '0;
          stb_d   = 1'b0;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // A new error wins over a same-cycle clear
    if (err_evt) begin
      irq_d = 1'b1;
      if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q <= ST_IDLE;
      req_q   <= '0;
      tmo_q   <= '0;
      cyc_q   <= '0;
      stb_q   <= 1'b0;
      ack_q   <= 1'b0;
      rdat_q  <= '0;
      irq_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      tmo_q   <= tmo_d;
      cyc_q   <= cyc_d;
      stb_q   <= stb_d;
      ack_q   <= ack_d;
      rdat_q  <= rdat_d;
      irq_q   <= irq_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.wbs_ack_o = ack_q;
  assign bus.wbs_dat_o = rdat_q;
  assign bus.s_cyc_o   = cyc_q;
  assign bus.s_stb_o   = stb_q;
  assign bus.s_we_o    = req_q.we;
  assign bus.s_sel_o   = req_q.sel;
  assign bus.s_adr_o   = req_q.adr;
  assign bus.s_dat_o   = req_q.dat;
  assign err_irq_o     = irq_q;
  assign err_cnt_o     = cnt_q;

endmodule

// File: tb/tb_user_wb_router.sv
// Self-checking bench for user_wb_router: vector table plus directed corner sequences.
module tb_user_wb_router;

  localparam int unsigned NS = 3;

  typedef struct {
    logic [31:0] adr;
    logic        we;
    logic [31:0] wdat;
    logic [3:0]  sel;
    int          ack_dly;   // BUSY cycle in which the addressed slave acks, 0 = never
    logic        noise;     // other slaves ack in the first BUSY cycle
    logic [31:0] rdat;
    logic [2:0]  exp_cyc;
    logic [31:0] exp_dat;
    logic        exp_err;
    int          exp_cycles;
  } vec_t;

  typedef struct {
    logic [31:0] dat;
    int          cycles;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       irq_clr = 1'b0;
  logic       err_irq;
  logic [7:0] err_cnt;

  int   n_chk = 0;
  int   n_fail = 0;
  logic       exp_irq = 1'b0;
  logic [7:0] exp_cnt = 8'd0;
  exp_t sb[$];
  vec_t vecs[9];

  user_wb_router_if #(.NSLV(NS)) bus ();

  user_wb_router #(.NSLV(NS), .TIMEOUT(255)) dut (
    .wb_clk_i  (clk),
    .wb_rst_n  (rst_n),
    .bus       (bus),
    .err_irq_o (err_irq),
    .irq_clr_i (irq_clr),
    .err_cnt_o (err_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running required finished");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " s_cyc"}, 32'(bus.s_cyc_o), 32'h0);
    chk({tag, " s_stb"}, 32'(bus.s_stb_o), 32'h0);
    chk({tag, " s_we"},  32'(bus.s_we_o),  32'h0);
    chk({tag, " s_sel"}, 32'(bus.s_sel_o), 32'h0);
    chk({tag, " s_adr"}, bus.s_adr_o, 32'h0);
    chk({tag, " s_dat"}, bus.s_dat_o, 32'h0);
    chk({tag, " ack"},   32'(bus.wbs_ack_o), 32'h0);
    chk({tag, " dat_o"}, bus.wbs_dat_o, 32'h0);
    chk({tag, " irq"},   32'(err_irq), 32'h0);
    chk({tag, " cnt"},   32'(err_cnt), 32'h0);
  endtask

  // One full transaction from a table record, with a reactive slave model
  task automatic run_vec(input int id, input vec_t v);
    int   n;
    int   busy;
    bit   done;
    exp_t e;
    exp_t got;
    e.dat = v.exp_dat;
    e.cycles = v.exp_cycles;
    sb.push_back(e);
    for (int k = 0; k < NS; k++)
      bus.s_dat_i[32*k +: 32] = v.exp_cyc[k] ? v.rdat : ~v.rdat;
    bus.wbs_adr_i = v.adr;
    bus.wbs_we_i  = v.we;
    bus.wbs_dat_i = v.wdat;
    bus.wbs_sel_i = v.sel;
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    n = 1;
    busy = 0;
    done = 1'b0;
    while (!done && n < 400) begin
      step();
      n++;
      bus.s_ack_i = '0;
      if (bus.wbs_ack_o) begin
        done = 1'b1;
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_stb_i = 1'b0;
        if (v.exp_err) begin
          exp_irq = 1'b1;
          if (exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
        end
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL v%0d spurious ack: got ack, required none", id);
        end else begin
          got = sb.pop_front();
          chk($sformatf("v%0d rdata", id), bus.wbs_dat_o, got.dat);
          chk($sformatf("v%0d cycles", id), 32'(n), 32'(got.cycles));
        end
        chk($sformatf("v%0d resp s_cyc", id), 32'(bus.s_cyc_o), 32'h0);
        chk($sformatf("v%0d resp s_stb", id), 32'(bus.s_stb_o), 32'h0);
        chk($sformatf("v%0d irq", id), 32'(err_irq), 32'(exp_irq));
        chk($sformatf("v%0d err_cnt", id), 32'(err_cnt), 32'(exp_cnt));
      end else if (bus.s_stb_o) begin
        busy++;
        if (busy == 1) begin
          chk($sformatf("v%0d s_cyc", id), 32'(bus.s_cyc_o), 32'(v.exp_cyc));
          chk($sformatf("v%0d s_we", id),  32'(bus.s_we_o),  32'(v.we));
          chk($sformatf("v%0d s_adr", id), bus.s_adr_o, v.adr);
          chk($sformatf("v%0d s_dat", id), bus.s_dat_o, v.wdat);
          chk($sformatf("v%0d s_sel", id), 32'(bus.s_sel_o), 32'(v.sel));
          if (v.noise) bus.s_ack_i = ~v.exp_cyc;
        end
        if (busy == v.ack_dly) bus.s_ack_i = bus.s_ack_i | v.exp_cyc;
      end
    end
    if (!done) begin
      n_chk++;
      n_fail++;
      $display("FAIL v%0d ack bound: got no ack in %0d cycles, required ack", id, n);
      bus.wbs_cyc_i = 1'b0;
      bus.wbs_stb_i = 1'b0;
      bus.s_ack_i = '0;
      sb.delete();
    end
    step();
    chk($sformatf("v%0d ack one cycle", id), 32'(bus.wbs_ack_o), 32'h0);
    chk($sformatf("v%0d dat held", id), bus.wbs_dat_o, v.exp_dat);
  endtask

  initial begin
    vec_t dv;
    exp_t got;
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
    bus.wbs_sel_i = '0;
    bus.wbs_adr_i = '0;
    bus.wbs_dat_i = '0;
    bus.s_ack_i   = '0;
    bus.s_dat_i   = '0;

    //          adr           we    wdat          sel    dly noise rdat          cyc     exp_dat       err   cyc
    vecs[0] = '{32'h3000_0010, 1'b0, 32'h0,        4'hF,  2,  1'b0, 32'h1234_5678, 3'b001, 32'h1234_5678, 1'b0, 4};
    vecs[1] = '{32'h30FF_FFF8, 1'b1, 32'hA5A5_A5A5, 4'hF, 1,  1'b0, 32'h600D_0002, 3'b100, 32'h600D_0002, 1'b0, 3};
    vecs[2] = '{32'h3001_0000, 1'b0, 32'h0,        4'hF,  0,  1'b0, 32'h1111_1111, 3'b010, 32'hDEAD_BEEF, 1'b1, 257};
    vecs[3] = '{32'h2000_0000, 1'b0, 32'h0,        4'hF,  0,  1'b0, 32'h2222_2222, 3'b000, 32'hDEAD_BEEF, 1'b1, 2};
    vecs[4] = '{32'h3001_FFF8, 1'b0, 32'h0,        4'h1,  3,  1'b1, 32'hCAFE_0001, 3'b010, 32'hCAFE_0001, 1'b0, 5};
    vecs[5] = '{32'h30FF_FFFF, 1'b1, 32'h0BAD_F00D, 4'h3, 1,  1'b0, 32'h0000_0005, 3'b100, 32'h0000_0005, 1'b0, 3};
    vecs[6] = '{32'h30FF_FFF0, 1'b0, 32'h0,        4'hC,  1,  1'b0, 32'h0000_0FF0, 3'b001, 32'h0000_0FF0, 1'b0, 3};
    vecs[7] = '{32'h3100_0000, 1'b1, 32'h7777_0000, 4'hF, 0,  1'b0, 32'h3333_3333, 3'b000, 32'hDEAD_BEEF, 1'b1, 2};
    vecs[8] = '{32'h3000_0000, 1'b0, 32'h0,        4'h8,  2,  1'b1, 32'h8765_4321, 3'b001, 32'h8765_4321, 1'b0, 4};

    // Outputs while reset is held
    repeat (2) step();
    chk_all_zero("reset");
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

    // Master drops cyc mid-BUSY: no ack, no error
    bus.wbs_adr_i = 32'h3000_0020;
    bus.wbs_we_i  = 1'b0;
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    step();
    chk("abort s_cyc busy", 32'(bus.s_cyc_o), 32'h1);
    repeat (2) step();
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    step();
    chk("abort s_cyc", 32'(bus.s_cyc_o), 32'h0);
    chk("abort s_stb", 32'(bus.s_stb_o), 32'h0);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("abort no ack %0d", i), 32'(bus.wbs_ack_o), 32'h0);
      step();
    end
    chk("abort err_cnt", 32'(err_cnt), 32'(exp_cnt));

    // irq clear coinciding with a new decode error: set wins
    dv = vecs[3];
    got.dat = 32'hDEAD_BEEF;
    got.cycles = 2;
    sb.push_back(got);
    bus.wbs_adr_i = dv.adr;
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    irq_clr = 1'b1;
    step();
    irq_clr = 1'b0;
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    if (exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
    chk("clr+err ack", 32'(bus.wbs_ack_o), 32'h1);
    got = sb.pop_front();
    chk("clr+err data", bus.wbs_dat_o, got.dat);
    chk("clr+err irq", 32'(err_irq), 32'h1);
    chk("clr+err cnt", 32'(err_cnt), 32'(exp_cnt));
    step();
    irq_clr = 1'b1;
    step();
    irq_clr = 1'b0;
    exp_irq = 1'b0;
    chk("irq clear", 32'(err_irq), 32'h0);

    // Error counter saturation
    for (int i = 0; i < 300; i++) run_vec(100 + i, vecs[3]);
    chk("cnt saturate", 32'(err_cnt), 32'hFF);

    // Reset pulse mid-BUSY
    bus.wbs_adr_i = 32'h3001_0000;
    bus.wbs_we_i  = 1'b1;
    bus.wbs_dat_i = 32'h5A5A_0000;
    bus.wbs_sel_i = 4'h6;
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    step();
    chk("rst busy s_cyc", 32'(bus.s_cyc_o), 32'h2);
    bus.s_ack_i = 3'b010;
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("mid-busy reset");
    exp_irq = 1'b0;
    exp_cnt = 8'd0;
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("post-reset no ack %0d", i), 32'(bus.wbs_ack_o), 32'h0);
    end
    bus.s_ack_i = '0;

    // Recovery after reset
    run_vec(900, vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/user_wb_router.md
USER_WB_ROUTER -- requirements
Module: user_wb_router

Interface
REQ-001 Parameter NSLV, default 3, SHALL set the number of downstream Wishbone slaves: 0 = user, 1 = gpio, 2 = debug.
REQ-002 Parameter TIMEOUT, default 255, SHALL set the number of BUSY cycles without a slave ack before the transaction is forced to complete.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 Ports SHALL be as follows, clock and reset first:
- wb_clk_i  in  1  clock
- wb_rst_n  in  1  asynchronous active-low reset
- wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  master request
- wbs_sel_i  in  4  byte select
- wbs_adr_i  in  32  address
- wbs_dat_i  in  32  write data
- wbs_ack_o  out  1  ack to master
- wbs_dat_o  out  32  read data to master
- s_cyc_o  out  NSLV  one-hot slave cycle
- s_stb_o, s_we_o  out  1 each  shared strobe and write enable
- s_sel_o  out  4  shared byte select
- s_adr_o, s_dat_o  out  32 each  shared registered address and write data
- s_ack_i  in  NSLV  per-slave ack
- s_dat_i  in  NSLV*32  per-slave read data, slave k at bits [32k+31:32k]
- err_irq_o  out  1  sticky error interrupt
- irq_clr_i  in  1  clears err_irq_o
- err_cnt_o  out  8  saturating error count

Function
REQ-005 Address decode SHALL apply only when adr[31:24]==8'h30; otherwise the transaction is DECERR.
- If adr[23:3]==21'h1FFFFF, select slave 2.
- Else if adr[23:16]==8'h01, select slave 1.
- Else select slave 0.
REQ-006 The FSM SHALL have the states IDLE, BUSY and RESP.
REQ-007 In IDLE, cyc&stb SHALL latch adr, dat, sel, we and the decoded index, then move to BUSY. On DECERR it SHALL move directly to RESP with the error flag set.
REQ-008 In BUSY, s_cyc_o[idx] and s_stb_o SHALL be 1 and all other s_cyc_o bits SHALL be 0.
REQ-009 In BUSY, s_ack_i[idx] SHALL capture s_dat_i[idx] and move the FSM to RESP; acks from non-selected slaves SHALL be ignored.
REQ-010 In RESP, wbs_ack_o SHALL be 1 for exactly one cycle with wbs_dat_o = the captured data, then the FSM SHALL return to IDLE; slave strobes SHALL be 0 in RESP.
REQ-011 A 9-bit timeout counter SHALL clear on BUSY entry and increment each BUSY cycle. When it equals TIMEOUT, the FSM SHALL move to RESP with wbs_dat_o=32'hDEADBEEF and the error flag set.
REQ-012 A DECERR response SHALL return wbs_dat_o=32'hDEADBEEF.
REQ-013 Minimum latency SHALL be 3 cycles from the stb sample to wbs_ack_o, for a slave that acks in its first BUSY cycle.
REQ-014 If wbs_cyc_i drops in BUSY, the block SHALL abort: slave signals go to 0 the next cycle, the FSM returns to IDLE, and no ack or error is raised.
REQ-015 On each error response, err_irq_o SHALL set and err_cnt_o SHALL increment, saturating at 8'hFF.
REQ-016 irq_clr_i SHALL clear err_irq_o. If irq_clr_i and a new error occur in the same cycle, set SHALL win.
REQ-017 wbs_dat_o SHALL hold its last value outside RESP.
REQ-018 A new request SHALL be sampled only in IDLE, so at most one transaction is outstanding.

Reset
REQ-019 While wb_rst_n=0 the following SHALL be 0:
- FSM state (IDLE) and timeout counter
- wbs_ack_o, wbs_dat_o
- s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o
- err_irq_o, err_cnt_o
REQ-020 Reset asserted mid-BUSY SHALL drop all strobes asynchronously, and no ack SHALL follow.

Structure
REQ-021 A shared package SHALL hold the state enum, the decode constants (8'h30, 21'h1FFFFF, 8'h01) and ERR_DATA=32'hDEADBEEF.
REQ-022 Address decode SHALL be the sole sub-module, user_wb_addr_decode (combinational; outputs idx and decerr).

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Read 0x3000_0010; slave 0 acks in its 2nd BUSY cycle with 0x1234_5678 -> s_cyc_o=001, wbs_ack_o one cycle, wbs_dat_o=0x1234_5678, 4 cycles total.
- Write 0x30FF_FFF8 data 0xA5A5_A5A5 -> s_cyc_o=100, s_we_o=1, s_dat_o=0xA5A5_A5A5; ack after slave 2 ack.
- Read 0x3001_0000 with slave 1 never acking -> ack after 255 BUSY cycles, data 0xDEADBEEF, err_irq_o=1, err_cnt_o=1.
- Read 0x2000_0000 -> no s_cyc_o, ack at cycle 2 with 0xDEADBEEF, err_cnt_o increments.
- cyc drops in BUSY, then irq_clr_i coincides with a new error -> no ack on abort; err_irq_o stays 1.
- 300 errors -> err_cnt_o=0xFF; reset pulse mid-BUSY -> all outputs 0 immediately.
